// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type, timing helpers and default delimiter for the UART frame transmitter.
// Optional feature macro: UART_FRAME_TX_PARITY_EN adds the PARITY state.
package uart_pkg;
  localparam logic [7:0] DEF_DELIM = 8'h17;
`ifdef UART_FRAME_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  function automatic int bit_clks(input int clk_freq, input int bps);
    return clk_freq / bps;
  endfunction
  // width of a counter running 0..n-1, never narrower than one bit
  function automatic int cnt_w(input int n);
    return n <= 2 ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter running 0..BIT_CLKS-1 with synchronous clear.
// Ports: sys_clk, sys_rst_n (sync active-low), clr (hold count at 0), bit_end (strobe on count BIT_CLKS-1).
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int BIT_CLKS = 434
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clr,
  output logic bit_end
);
  localparam int CW = cnt_w(BIT_CLKS);
  logic [CW-1:0] cnt;
  assign bit_end = cnt == CW'(BIT_CLKS - 1);
  always_ff @(posedge sys_clk)
    if (!sys_rst_n || clr) cnt <= '0;
    else cnt <= bit_end ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: serialises DELIM then the DATA_W-bit payload LSB byte first as 8N1/8N2 (8E1/8E2 with parity).
// Ports: sys_clk, sys_rst_n (sync active-low), s_data/s_valid/s_ready (payload handshake),
//        busy (frame in progress), done (one-cycle end-of-frame pulse), tx (serial line, idles high).
// Optional feature macro: UART_FRAME_TX_PARITY_EN inserts an even-parity bit after bit 7 of every byte.
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int          UART_BPS  = 115200,
  parameter int          CLK_FREQ  = 50_000_000,
  parameter int          DATA_W    = 64,
  parameter logic [7:0]  DELIM     = DEF_DELIM,
  parameter int          STOP_BITS = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              busy,
  output logic              done,
  output logic              tx
);
  localparam int BIT_CLKS = bit_clks(CLK_FREQ, UART_BPS);
  localparam int NBYTES   = DATA_W / 8;
  localparam int BW       = cnt_w(NBYTES + 1);
  state_t            state;
  logic [DATA_W-1:0] pay;
  logic [7:0]        cur;
  logic [2:0]        bit_cnt;
  logic              stop_cnt;
  logic [BW-1:0]     byte_cnt;
  logic              par;
  logic              bit_end;
  // baud counter is held at zero while idle so each frame starts with fresh bit phase
  uart_baud_gen #(.BIT_CLKS(BIT_CLKS)) u_baud (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .clr      (state == IDLE),
    .bit_end  (bit_end)
  );
  // cur holds the byte on the wire and shifts right per data bit; pay feeds the next byte from its low end
  always_ff @(posedge sys_clk)
    if (!sys_rst_n) begin
      state    <= IDLE;
      tx       <= 1'b1;
      s_ready  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      pay      <= '0;
      cur      <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      byte_cnt <= '0;
      par      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE:
          if (s_valid && s_ready) begin
            pay     <= s_data;
            cur     <= DELIM;
            tx      <= 1'b0;
            s_ready <= 1'b0;
            busy    <= 1'b1;
            state   <= START;
          end
        START:
          if (bit_end) begin
            tx      <= cur[0];
            par     <= ^cur;
            bit_cnt <= '0;
            state   <= DATA;
          end
        DATA:
          if (bit_end) begin
            if (bit_cnt == 3'd7) begin
`ifdef UART_FRAME_TX_PARITY_EN
              tx    <= par;
              state <= PARITY;
`else
              tx       <= 1'b1;
              stop_cnt <= 1'b0;
              state    <= STOP;
`endif
            end else begin
              tx      <= cur[1];
              cur     <= cur >> 1;
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
`ifdef UART_FRAME_TX_PARITY_EN
        PARITY:
          if (bit_end) begin
            tx       <= 1'b1;
            stop_cnt <= 1'b0;
            state    <= STOP;
          end
`endif
        STOP:
          if (bit_end) begin
            if (stop_cnt == 1'(STOP_BITS - 1)) begin
              if (byte_cnt == BW'(NBYTES)) begin
                byte_cnt <= '0;
                s_ready  <= 1'b1;
                busy     <= 1'b0;
                done     <= 1'b1;
                state    <= IDLE;
              end else begin
                byte_cnt <= byte_cnt + 1'b1;
                cur      <= pay[7:0];
                pay      <= pay >> 8;
                tx       <= 1'b0;
                state    <= START;
              end
            end else stop_cnt <= stop_cnt + 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_frame_tx.sv
// tb_uart_frame_tx: randomized scoreboard bench; expected line bit sequences are queued per accepted payload and a monitor compares tx every cycle.
module tb_uart_frame_tx;
  localparam int CLK_FREQ  = 1_843_200;
  localparam int UART_BPS  = 115200;
  localparam int B         = CLK_FREQ / UART_BPS;
  localparam int DATA_W    = 32;
  localparam int NB        = DATA_W / 8;
  localparam int STOP_BITS = 2;
`ifdef UART_FRAME_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int BPB  = 10 + STOP_BITS - 1 + PB;
  localparam int FLEN = (NB + 1) * BPB;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic s_valid = 1'b0;
  logic [DATA_W-1:0] s_data = '0;
  logic s_ready, busy, done, tx;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit exp_q[$];
  bit mon_active = 1'b0;

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  uart_frame_tx #(
    .UART_BPS (UART_BPS),
    .CLK_FREQ (CLK_FREQ),
    .DATA_W   (DATA_W),
    .DELIM    (8'h17),
    .STOP_BITS(STOP_BITS)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .busy     (busy),
    .done     (done),
    .tx       (tx)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference: the line level of every bit period of a whole frame
  task automatic push_frame(input logic [DATA_W-1:0] d);
    logic [7:0] b;
    for (int k = 0; k <= NB; k++) begin
      if (k == 0) b = 8'h17;
      else b = 8'(d >> (8 * (k - 1)));
      exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
      if (PB == 1) exp_q.push_back(^b);
      for (int s = 0; s < STOP_BITS; s++) exp_q.push_back(1'b1);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send(input logic [DATA_W-1:0] d, output int acc_cyc);
    int n = 0;
    acc_cyc = -1;
    s_data = d;
    s_valid = 1'b1;
    while (!s_ready && n < FLEN * B + 10) begin
      tick();
      n++;
    end
    if (!s_ready) chk("ready_timeout", 64'(s_ready), 64'd1);
    else begin
      push_frame(d);
      acc_cyc = cyc;
    end
    tick();
  endtask

  initial begin : monitor
    bit e, aborted;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst_n) continue;
      if (done === 1'b1) chk("spurious_done", 64'(done), 64'd0);
      if (tx === 1'b0) begin
        mon_active = 1'b1;
        aborted = 1'b0;
        if (exp_q.size() < FLEN) begin
          chk("unexpected_frame", 64'(exp_q.size()), 64'(FLEN));
          aborted = 1'b1;
        end
        for (int n = 0; n < FLEN && !aborted; n++) begin
          e = exp_q.pop_front();
          for (int c = 0; c < B; c++) begin
            if (n > 0 || c > 0) @(negedge sys_clk);
            if (!sys_rst_n) begin
              aborted = 1'b1;
              break;
            end
            chk($sformatf("tx_bit%0d_cyc%0d", n, c), 64'(tx), 64'(e));
            if (c == 0) chk($sformatf("busy_bit%0d", n), {62'd0, busy, s_ready}, 64'd2);
          end
        end
        if (aborted) exp_q.delete();
        else begin
          @(negedge sys_clk);
          if (sys_rst_n) chk("frame_end", {60'd0, done, busy, s_ready, tx}, 64'b1011);
        end
        mon_active = 1'b0;
      end
    end
  end

  initial begin : driver
    int a0, a1, n;
    repeat (3) tick();
    chk("rst_state", {60'd0, tx, s_ready, busy, done}, 64'b1100);
    sys_rst_n = 1'b1;
    tick();
    send(32'h89AB_CDEF, a0);
    s_valid = 1'b0;
    send(32'hA55A_00FF, a0);
    s_valid = 1'b0;
    repeat (3) tick();
    // held valid: next payload taken in the first idle cycle, junk while busy is ignored
    send(32'h0000_0001, a0);
    s_data = $urandom;
    send(32'h0000_0002, a1);
    chk("b2b_gap", 64'(a1 - a0), 64'(FLEN * B + 1));
    s_data = $urandom;
    a0 = a1;
    send($urandom, a1);
    chk("b2b_gap2", 64'(a1 - a0), 64'(FLEN * B + 1));
    s_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 4)) tick();
      send($urandom, a0);
      s_valid = 1'b0;
      s_data = $urandom;
    end
    // abort mid-frame, then a clean frame
    send(32'hDEAD_BEEF, a0);
    s_valid = 1'b0;
    repeat (100) tick();
    sys_rst_n = 1'b0;
    tick();
    chk("abort_state", {60'd0, tx, s_ready, busy, done}, 64'b1100);
    repeat (2) tick();
    sys_rst_n = 1'b1;
    tick();
    send(32'h1234_5678, a0);
    s_valid = 1'b0;
    n = 0;
    while ((exp_q.size() != 0 || mon_active || busy) && n < 2 * FLEN * B) begin
      tick();
      n++;
    end
    chk("drain", {62'd0, exp_q.size() != 0, mon_active}, 64'd0);
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
